clock_set_ctrl: RTL and testbench

//  Mode and time-set sequencer for the digital clock. Drives the en and clear

---
 rtl/clock_set_ctrl.sv | 157 +++++++++++++++
 tb/tb_clock_set_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Mode and time-set sequencer for the digital clock: drives the en/clear inputs
// of the seconds, minutes and hours BCD counters, with key auto-repeat, blink and idle timeout.
module clock_set_ctrl #(
   parameter int unsigned HOLD_CYC   = 50_000_000,
   parameter int unsigned REPEAT_CYC = 10_000_000,
   parameter int unsigned TIMEOUT_S  = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       key_mode,
   input  logic       key_inc,
   input  logic       inc_lvl,
   input  logic       carry_s,
   input  logic       carry_m,
   output logic       en_sec,
   output logic       en_min,
   output logic       en_hour,
   output logic       clr_sec,
   output logic [1:0] mode,
   output logic       blink
);

   localparam int unsigned HOLD_W = (HOLD_CYC > 0)   ? $clog2(HOLD_CYC + 1) : 1;
   localparam int unsigned REP_W  = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC)   : 1;
   localparam int unsigned TO_W   = (TIMEOUT_S > 1)  ? $clog2(TIMEOUT_S)    : 1;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2,
      SET_SEC  = 2'd3
   } mode_t;

   mode_t             r_mode;
   logic [HOLD_W-1:0] r_hold;
   logic [REP_W-1:0]  r_rep;
   logic [TO_W-1:0]   r_to;
   logic              r_blink;
   logic              r_en_sec;
   logic              r_en_min;
   logic              r_en_hour;
   logic              r_clr_sec;

   mode_t             w_mode_nxt;
   logic              w_mode_chg;
   logic [HOLD_W-1:0] w_hold_nxt;
   logic [REP_W-1:0]  w_rep_nxt;
   logic [TO_W-1:0]   w_to_nxt;
   logic              w_blink_nxt;
   logic              w_en_sec_nxt;
   logic              w_en_min_nxt;
   logic              w_en_hour_nxt;
   logic              w_clr_sec_nxt;

   logic              w_in_set;
   logic              w_hold_done;
   logic              w_rep_fire;
   logic              w_act;
   logic              w_expire;
   logic              w_step;
   logic              w_run_tick;

   // Auto-repeat fires once the hold phase is complete and the repeat phase wraps to zero.
   assign w_in_set    = (r_mode != RUN);
   assign w_hold_done = (r_hold == HOLD_W'(HOLD_CYC));
   assign w_rep_fire  = w_in_set & inc_lvl & w_hold_done & (r_rep == '0);
   assign w_act       = w_in_set & (key_inc | w_rep_fire);
   assign w_expire    = w_in_set & tick_1hz & ~w_act & (r_to == TO_W'(TIMEOUT_S - 1));
   assign w_step      = w_act & ~key_mode & ~w_expire;
   assign w_run_tick  = ~w_in_set & tick_1hz;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mode    <= RUN;
         r_hold    <= '0;
         r_rep     <= '0;
         r_to      <= '0;
         r_blink   <= 1'b0;
         r_en_sec  <= 1'b0;
         r_en_min  <= 1'b0;
         r_en_hour <= 1'b0;
         r_clr_sec <= 1'b0;
      end else begin
         r_mode    <= w_mode_nxt;
         r_hold    <= w_hold_nxt;
         r_rep     <= w_rep_nxt;
         r_to      <= w_to_nxt;
         r_blink   <= w_blink_nxt;
         r_en_sec  <= w_en_sec_nxt;
         r_en_min  <= w_en_min_nxt;
         r_en_hour <= w_en_hour_nxt;
         r_clr_sec <= w_clr_sec_nxt;
      end
   end

   always_comb begin
      w_mode_nxt    = r_mode;
      w_mode_chg    = 1'b0;
      w_hold_nxt    = r_hold;
      w_rep_nxt     = r_rep;
      w_to_nxt      = r_to;
      w_blink_nxt   = r_blink;
      w_en_sec_nxt  = 1'b0;
      w_en_min_nxt  = 1'b0;
      w_en_hour_nxt = 1'b0;
      w_clr_sec_nxt = 1'b0;

      case (r_mode)
         RUN:      if (key_mode) w_mode_nxt = SET_HOUR;
         SET_HOUR: if (key_mode) w_mode_nxt = SET_MIN;
         SET_MIN:  if (key_mode) w_mode_nxt = SET_SEC;
         default:  if (key_mode) w_mode_nxt = RUN;
      endcase
      if (w_expire) w_mode_nxt = RUN;
      w_mode_chg = (w_mode_nxt != r_mode);

      // Hold counter saturates at HOLD_CYC, then the repeat counter cycles 0..REPEAT_CYC-1.
      if (w_mode_chg || !w_in_set || !inc_lvl) begin
         w_hold_nxt = '0;
         w_rep_nxt  = '0;
      end else if (!w_hold_done) begin
         w_hold_nxt = r_hold + HOLD_W'(1);
      end else if (r_rep == REP_W'(REPEAT_CYC - 1)) begin
         w_rep_nxt = '0;
      end else begin
         w_rep_nxt = r_rep + REP_W'(1);
      end

      if ((w_mode_nxt == RUN) || key_mode || w_act) begin
         w_to_nxt = '0;
      end else if (tick_1hz) begin
         w_to_nxt = r_to + TO_W'(1);
      end

      if (w_mode_nxt == RUN) begin
         w_blink_nxt = 1'b0;
      end else if (w_mode_chg) begin
         w_blink_nxt = 1'b1;
      end else if (tick_1hz) begin
         w_blink_nxt = ~r_blink;
      end

      w_en_sec_nxt  = w_run_tick;
      w_en_min_nxt  = (w_run_tick & carry_s) | (w_step & (r_mode == SET_MIN));
      w_en_hour_nxt = (w_run_tick & carry_s & carry_m) | (w_step & (r_mode == SET_HOUR));
      w_clr_sec_nxt = w_step & (r_mode == SET_SEC);
   end

   assign en_sec  = r_en_sec;
   assign en_min  = r_en_min;
   assign en_hour = r_en_hour;
   assign clr_sec = r_clr_sec;
   assign mode    = 2'(r_mode);
   assign blink   = r_blink;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_clock_set_ctrl;

   localparam int HOLD = 20;
   localparam int REP  = 5;
   localparam int TOS  = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick_1hz;
   logic       key_mode;
   logic       key_inc;
   logic       inc_lvl;
   logic       carry_s;
   logic       carry_m;
   logic       en_sec;
   logic       en_min;
   logic       en_hour;
   logic       clr_sec;
   logic [1:0] mode;
   logic       blink;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   int m_mode;
   int m_held;
   int m_idle;
   bit m_blink;
   bit e_sec;
   bit e_min;
   bit e_hour;
   bit e_clr;

   always #5 clk = ~clk;

   clock_set_ctrl #(
      .HOLD_CYC  (HOLD),
      .REPEAT_CYC(REP),
      .TIMEOUT_S (TOS)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .tick_1hz(tick_1hz),
      .key_mode(key_mode),
      .key_inc (key_inc),
      .inc_lvl (inc_lvl),
      .carry_s (carry_s),
      .carry_m (carry_m),
      .en_sec  (en_sec),
      .en_min  (en_min),
      .en_hour (en_hour),
      .clr_sec (clr_sec),
      .mode    (mode),
      .blink   (blink)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: m_held = consecutive counted inc_lvl cycles, m_idle = ticks since last activity.
   task automatic model_step();
      int nxt;
      bit rep, act, expire, step;
      if (m_mode == 0) begin
         e_sec  = tick_1hz;
         e_min  = tick_1hz && carry_s;
         e_hour = tick_1hz && carry_s && carry_m;
         e_clr  = 1'b0;
         nxt    = key_mode ? 1 : 0;
         m_held = 0;
         m_idle = 0;
         m_blink = (nxt != 0);
      end else begin
         rep    = inc_lvl && (m_held >= HOLD) && (((m_held - HOLD) % REP) == 0);
         act    = key_inc || rep;
         expire = tick_1hz && !act && (m_idle + 1 >= TOS);
         nxt    = expire ? 0 : (key_mode ? (m_mode + 1) % 4 : m_mode);
         step   = act && !key_mode && !expire;
         e_sec  = 1'b0;
         e_hour = step && (m_mode == 1);
         e_min  = step && (m_mode == 2);
         e_clr  = step && (m_mode == 3);
         m_held = (nxt == m_mode && inc_lvl) ? m_held + 1 : 0;
         if (nxt == 0 || key_mode || act) m_idle = 0;
         else if (tick_1hz) m_idle++;
         if (nxt == 0) m_blink = 1'b0;
         else if (nxt != m_mode) m_blink = 1'b1;
         else if (tick_1hz) m_blink = !m_blink;
      end
      m_mode = nxt;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_mode = 0; m_held = 0; m_idle = 0; m_blink = 1'b0;
         e_sec = 1'b0; e_min = 1'b0; e_hour = 1'b0; e_clr = 1'b0;
      end else begin
         model_step();
      end
      #2;
      if (chk_en) begin
         check("cyc_en_sec",  int'(en_sec),  int'(e_sec));
         check("cyc_en_min",  int'(en_min),  int'(e_min));
         check("cyc_en_hour", int'(en_hour), int'(e_hour));
         check("cyc_clr_sec", int'(clr_sec), int'(e_clr));
         check("cyc_mode",    int'(mode),    m_mode);
         check("cyc_blink",   int'(blink),   int'(m_blink));
      end
   end

   task automatic tk();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int pulses;
      int p_t, p_i, p_m, p_l;
      rst = 1'b1; tick_1hz = 1'b0; key_mode = 1'b0; key_inc = 1'b0;
      inc_lvl = 1'b0; carry_s = 1'b0; carry_m = 1'b0;
      tk(); tk();
      #1;
      check("rst_mode",    int'(mode),    0);
      check("rst_en_sec",  int'(en_sec),  0);
      check("rst_clr_sec", int'(clr_sec), 0);
      check("rst_blink",   int'(blink),   0);
      rst = 1'b0;
      chk_en = 1'b1;
      tk();

      // RUN: tick with both carries set
      tick_1hz = 1'b1; carry_s = 1'b1; carry_m = 1'b1;
      tk();
      tick_1hz = 1'b0;
      #1;
      check("t2_en_sec",  int'(en_sec),  1);
      check("t2_en_min",  int'(en_min),  1);
      check("t2_en_hour", int'(en_hour), 1);
      tk();
      #1;
      check("t2_en_sec_off",  int'(en_sec),  0);
      check("t2_en_hour_off", int'(en_hour), 0);
      carry_s = 1'b0; carry_m = 1'b0;

      // Three mode presses to SET_SEC, then a step
      repeat (3) begin
         key_mode = 1'b1; tk(); key_mode = 1'b0; tk();
      end
      #1;
      check("t3_mode", int'(mode), 3);
      key_inc = 1'b1;
      tk();
      key_inc = 1'b0;
      #1;
      check("t3_clr_sec", int'(clr_sec), 1);
      check("t3_mode2",   int'(mode),    3);
      tk();
      #1;
      check("t3_clr_off", int'(clr_sec), 0);
      tick_1hz = 1'b1;
      tk();
      tick_1hz = 1'b0;
      #1;
      check("t3_no_en_sec", int'(en_sec), 0);
      key_mode = 1'b1; tk(); key_mode = 1'b0;
      #1;
      check("t3_back_run", int'(mode), 0);

      // SET_HOUR: simultaneous mode key and step
      key_mode = 1'b1; tk(); key_mode = 1'b0;
      #1;
      check("t6_mode_hour", int'(mode),  1);
      check("t6_blink_on",  int'(blink), 1);
      key_mode = 1'b1; key_inc = 1'b1;
      tk();
      key_mode = 1'b0; key_inc = 1'b0;
      #1;
      check("t6_mode_min", int'(mode),    2);
      check("t6_no_hour",  int'(en_hour), 0);

      // SET_MIN auto-repeat window
      pulses = 0;
      inc_lvl = 1'b1; key_inc = 1'b1;
      for (int i = 0; i < HOLD + 2 * REP; i++) begin
         tk();
         key_inc = 1'b0;
         if (i == HOLD + 2 * REP - 1) inc_lvl = 1'b0;
         #1;
         pulses += int'(en_min);
      end
      repeat (3) begin
         tk(); #1; pulses += int'(en_min);
      end
      check("t4_en_min_pulses", pulses, 3);

      // Async reset mid-SET_MIN with inc_lvl held
      inc_lvl = 1'b1;
      repeat (5) tk();
      #2 rst = 1'b1;
      #1;
      check("t1_mode",    int'(mode),    0);
      check("t1_en_min",  int'(en_min),  0);
      check("t1_en_hour", int'(en_hour), 0);
      check("t1_en_sec",  int'(en_sec),  0);
      check("t1_clr_sec", int'(clr_sec), 0);
      check("t1_blink",   int'(blink),   0);
      tk(); tk();
      rst = 1'b0;
      pulses = 0;
      repeat (HOLD + 2 * REP + 5) begin
         tk(); #1; pulses += int'(en_min) + int'(en_hour) + int'(clr_sec);
      end
      check("t1_no_steps", pulses, 0);
      check("t1_still_run", int'(mode), 0);
      inc_lvl = 1'b0;

      // SET_HOUR idle timeout
      key_mode = 1'b1; tk(); key_mode = 1'b0;
      for (int i = 0; i < TOS; i++) begin
         repeat (2) tk();
         tick_1hz = 1'b1;
         tk();
         tick_1hz = 1'b0;
         #1;
         if (i < TOS - 1) check("t5_hold_mode", int'(mode), 1);
      end
      check("t5_timeout_mode",  int'(mode),  0);
      check("t5_timeout_blink", int'(blink), 0);

      // Randomized segments with varying event rates
      for (int seg = 0; seg < 12; seg++) begin
         p_t = int'($urandom_range(2, 10));
         p_i = int'($urandom_range(4, 60));
         p_m = int'($urandom_range(8, 80));
         p_l = int'($urandom_range(5, 60));
         for (int c = 0; c < 300; c++) begin
            tick_1hz = ($urandom_range(0, p_t - 1) == 0);
            key_inc  = ($urandom_range(0, p_i - 1) == 0);
            key_mode = ($urandom_range(0, p_m - 1) == 0);
            carry_s  = ($urandom_range(0, 2) == 0);
            carry_m  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, p_l - 1) == 0) inc_lvl = ~inc_lvl;
            tk();
         end
      end
      tick_1hz = 1'b0; key_inc = 1'b0; key_mode = 1'b0; inc_lvl = 1'b0;
      tk(); tk();
      #3;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
